fetch_stage: RTL and testbench



---
 rtl/riscv_pkg.sv | 28 ++
 rtl/if_id_reg.sv | 48 ++++
 rtl/fetch_stage.sv | 150 +++++++++++++++
 tb/tb_fetch_stage.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline definitions: widths, NOP encoding, opcodes and fetch FSM states.
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;

  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } fetch_state_t;

  // Payload carried from fetch into the IF/ID slot.
  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_pkt_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline slot: load, flush and drain, with NOP fill whenever the slot is empty.
module if_id_reg
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  fetch_pkt_t load_pkt_i,
  input  logic       flush_i,
  input  logic       id_ready_i,
  output logic       valid_o,
  output fetch_pkt_t pkt_o
);

  logic       valid_q, valid_d;
  fetch_pkt_t pkt_q, pkt_d;

  // Flush beats load beats drain; an emptied slot always shows NOP.
  always_comb begin
    valid_d = valid_q;
    pkt_d   = pkt_q;
    if (flush_i) begin
      valid_d     = 1'b0;
      pkt_d.instr = NOP_INSTR;
    end else if (load_i) begin
      valid_d = 1'b1;
      pkt_d   = load_pkt_i;
    end else if (valid_q && id_ready_i) begin
      valid_d     = 1'b0;
      pkt_d.instr = NOP_INSTR;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      pkt_q.instr <= NOP_INSTR;
      pkt_q.pc    <= XLEN'(0);
    end else begin
      valid_q <= valid_d;
      pkt_q   <= pkt_d;
    end
  end

  assign valid_o = valid_q;
  assign pkt_o   = pkt_q;

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: PC, single-outstanding imem requests, IF/ID slot.
// Optional FETCH_PERF_EN adds perf_fetched / perf_stall / perf_flush counters.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_id_valid,
  output logic [ILEN-1:0] if_id_instr,
  output logic [XLEN-1:0] if_id_pc,
  input  logic            id_ready
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_stall,
  output logic [31:0]     perf_flush
`endif
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            drop_q, drop_d;
  logic [ILEN-1:0] hold_q, hold_d;

  logic            load_c;
  fetch_pkt_t      load_pkt_c;
  fetch_pkt_t      slot_pkt;
  logic            slot_free_c;
  logic [XLEN-1:0] redirect_tgt_c;

  assign slot_free_c    = !if_id_valid || id_ready;
  assign redirect_tgt_c = redirect_pc & ~XLEN'(3);
  assign imem_req_valid = (state_q == S_REQ) && !redirect_valid;
  assign imem_req_addr  = pc_q;

  // Next-state logic; a redirect overrides whatever the FSM would otherwise do.
  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    drop_d           = drop_q;
    hold_d           = hold_q;
    load_c           = 1'b0;
    load_pkt_c.instr = imem_rsp_data;
    load_pkt_c.pc    = pc_q;

    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (imem_req_valid && imem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else if (slot_free_c) begin
            load_c  = 1'b1;
            pc_d    = pc_q + XLEN'(4);
            state_d = S_REQ;
          end else begin
            hold_d  = imem_rsp_data;
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (id_ready) begin
          load_c           = 1'b1;
          load_pkt_c.instr = hold_q;
          pc_d             = pc_q + XLEN'(4);
          state_d          = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (redirect_valid) begin
      pc_d   = redirect_tgt_c;
      load_c = 1'b0;
      hold_d = ILEN'(0);
      case (state_q)
        S_WAIT: begin
          drop_d  = !imem_rsp_valid;
          state_d = imem_rsp_valid ? S_REQ : S_WAIT;
        end
        S_HOLD:  state_d = S_REQ;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      drop_q  <= 1'b0;
      hold_q  <= ILEN'(0);
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
      hold_q  <= hold_d;
    end
  end

  if_id_reg u_if_id_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (load_c),
    .load_pkt_i (load_pkt_c),
    .flush_i    (redirect_valid),
    .id_ready_i (id_ready),
    .valid_o    (if_id_valid),
    .pkt_o      (slot_pkt)
  );

  assign if_id_instr = slot_pkt.instr;
  assign if_id_pc    = slot_pkt.pc;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_stall_q, perf_flush_q;

  // Free-running event counters; wrap naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_q <= 32'd0;
      perf_stall_q   <= 32'd0;
      perf_flush_q   <= 32'd0;
    end else begin
      if (load_c)             perf_fetched_q <= perf_fetched_q + 32'd1;
      if (state_q == S_HOLD)  perf_stall_q   <= perf_stall_q + 32'd1;
      if (redirect_valid)     perf_flush_q   <= perf_flush_q + 32'd1;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
  assign perf_flush   = perf_flush_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized traffic vs a transaction-level model.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic        id_ready = 1'b0;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_stall, perf_flush;
`endif

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_id_valid    (if_id_valid),
    .if_id_instr    (if_id_instr),
    .if_id_pc       (if_id_pc),
    .id_ready       (id_ready)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall),
    .perf_flush     (perf_flush)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Model of the fetch stream: which word sits in the slot and which address must be requested next.
  bit          m_valid = 0;
  logic [31:0] m_instr = NOP;
  logic [31:0] m_pc = 32'h0;
  logic [31:0] exp_pc = 32'h0;
  logic [31:0] acc_addr = 32'h0;
  logic [31:0] hold_addr = 32'h0;
  bit          pending = 0;
  bit          dut_out = 0;
  bit          live = 0;
  bit          started = 0;
  int unsigned m_fetched = 0, m_stall = 0, m_flush = 0;

  // Instruction memory: one outstanding request, response after lat_cfg extra cycles.
  bit          mem_out = 0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = 32'h0;
  int          lat_cfg = 0;

  bit          chk_en = 0;
  bit          seen_req = 0;
  logic [31:0] seen_addr = 32'h0;
  int          cyc = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h4) return 32'h00A0_0093;
    return a ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic peek();
    @(posedge clk);
    #1;
  endtask

  // One clock cycle: check slot state, drive inputs, check request, advance memory and model.
  task automatic tick(input bit rst_in, input bit rdr, input logic [31:0] rpc,
                      input bit idr, input bit rdy);
    bit exp_req, rsp, ld, was_pending;
    logic [31:0] ld_addr;
    @(negedge clk);
    cyc++;
    if (chk_en) begin
      chk("if_id_valid", 32'(if_id_valid), 32'(m_valid));
      chk("if_id_instr", if_id_instr, m_instr);
      if (m_valid) chk("if_id_pc", if_id_pc, m_pc);
`ifdef FETCH_PERF_EN
      chk("perf_fetched", perf_fetched, m_fetched);
      chk("perf_stall", perf_stall, m_stall);
      chk("perf_flush", perf_flush, m_flush);
`endif
    end
    rst_n          = rst_in;
    redirect_valid = rdr;
    redirect_pc    = rpc;
    id_ready       = idr;
    imem_req_ready = rdy && !mem_out;
    imem_rsp_valid = mem_out && (mem_cnt == 0);
    imem_rsp_data  = imem_rsp_valid ? mem_word(mem_addr) : $urandom;
    #1;
    exp_req = rst_in && started && !dut_out && !pending && !rdr;
    chk("imem_req_valid", 32'(imem_req_valid), 32'(exp_req));
    if (exp_req) chk("imem_req_addr", imem_req_addr, exp_pc);
    if (!rst_in) begin
      chk("rst_if_id_valid", 32'(if_id_valid), 32'h0);
      chk("rst_if_id_instr", if_id_instr, NOP);
      chk("rst_if_id_pc", if_id_pc, 32'h0);
    end
    seen_req  = imem_req_valid;
    seen_addr = imem_req_addr;

    rsp = imem_rsp_valid;
    if (rsp) mem_out = 0;
    else if (mem_out && mem_cnt > 0) mem_cnt--;
    if (exp_req && imem_req_ready) begin
      mem_out  = 1;
      mem_addr = exp_pc;
      mem_cnt  = lat_cfg;
    end

    if (!rst_in) begin
      m_valid = 0; m_instr = NOP; m_pc = 32'h0; exp_pc = 32'h0;
      pending = 0; dut_out = 0; live = 0; started = 0;
      m_fetched = 0; m_stall = 0; m_flush = 0;
    end else begin
      was_pending = pending;
      if (rdr) begin
        m_valid = 0; m_instr = NOP;
        pending = 0; live = 0;
        exp_pc  = rpc & 32'hFFFF_FFFC;
        if (rsp) dut_out = 0;
        m_flush++;
      end else begin
        ld = 0; ld_addr = 32'h0;
        if (rsp && dut_out) begin
          dut_out = 0;
          if (live) begin
            live = 0;
            if (!m_valid || idr) begin ld = 1; ld_addr = acc_addr; end
            else begin pending = 1; hold_addr = acc_addr; end
          end
        end else if (pending && idr) begin
          ld = 1; ld_addr = hold_addr; pending = 0;
        end
        if (ld) begin
          m_valid = 1; m_pc = ld_addr; m_instr = mem_word(ld_addr);
          exp_pc = ld_addr + 32'd4;
          m_fetched++;
        end else if (m_valid && idr) begin
          m_valid = 0; m_instr = NOP;
        end
      end
      if (was_pending) m_stall++;
      if (exp_req && imem_req_ready) begin
        dut_out = 1; live = 1; acc_addr = exp_pc;
      end
      started = 1;
    end
    chk_en = 1;
  endtask

  task automatic wait_req(input logic [31:0] exp, input string name, input bit idr, output int at);
    at = -1;
    for (int i = 0; i < 20; i++) begin
      tick(1, 0, 32'h0, idr, 1);
      if (seen_req) begin at = cyc; break; end
    end
    if (at < 0) begin
      checks++; errors++;
      $display("FAIL %s: no request within 20 cycles, expected addr %h", name, exp);
    end else chk(name, seen_addr, exp);
  endtask

  initial begin
    int t0, t1, nreq, dummy;
    bit rb;
    // Reset sequence and steady zero-wait fetch.
    for (int i = 0; i < 3; i++) tick(0, 0, 32'h0, 0, 0);
    wait_req(32'h0, "first_req_addr", 1, t0);
    chk("first_req_cycle", 32'(t0), 32'd5);
    wait_req(32'h4, "second_req_addr", 0, t1);
    chk("req_spacing", 32'(t1 - t0), 32'd2);

    // Back-pressure: word at PC 4 parks in the hold register.
    nreq = 0;
    for (int i = 0; i < 5; i++) begin
      tick(1, 0, 32'h0, 0, 1);
      if (seen_req) nreq++;
    end
    chk("hold_no_req", 32'(nreq), 32'd0);
    peek();
    chk("hold_slot_pc", if_id_pc, 32'h0);
    chk("hold_slot_instr", if_id_instr, 32'h0000_0013);
    tick(1, 0, 32'h0, 1, 1);
    peek();
    chk("release_pc", if_id_pc, 32'h4);
    chk("release_instr", if_id_instr, 32'h00A0_0093);

    // Redirect while the fetch of PC 8 is outstanding.
    lat_cfg = 2;
    wait_req(32'h8, "req_pc8", 1, dummy);
    tick(1, 1, 32'h100, 1, 1);
    peek();
    chk("redirect_wait_valid", 32'(if_id_valid), 32'h0);
    lat_cfg = 0;
    wait_req(32'h100, "redirect_target_req", 1, dummy);
    for (int i = 0; i < 10; i++) begin
      tick(1, 0, 32'h0, 0, 1);
      peek();
      if (if_id_valid) break;
    end
    chk("redirect_slot_pc", if_id_pc, 32'h100);
    chk("redirect_slot_instr", if_id_instr, 32'h0000_0113);

    // Redirect coincident with the response; low address bits ignored.
    wait_req(32'h104, "req_104", 1, dummy);
    tick(1, 1, 32'h203, 1, 1);
    peek();
    chk("coincident_valid", 32'(if_id_valid), 32'h0);
    wait_req(32'h200, "coincident_target_req", 1, dummy);

    // PC wrap at the top of the address space.
    tick(1, 1, 32'hFFFF_FFFC, 1, 1);
    wait_req(32'hFFFF_FFFC, "wrap_base_req", 1, dummy);
    lat_cfg = 3;
    wait_req(32'h0, "wrap_next_req", 1, dummy);

    // Reset while waiting; the late response must be ignored.
    tick(1, 0, 32'h0, 1, 1);
    tick(0, 0, 32'h0, 1, 1);
    tick(0, 0, 32'h0, 1, 1);
`ifdef FETCH_PERF_EN
    peek();
    chk("rst_perf_fetched", perf_fetched, 32'h0);
    chk("rst_perf_stall", perf_stall, 32'h0);
    chk("rst_perf_flush", perf_flush, 32'h0);
`endif
    lat_cfg = 0;
    wait_req(32'h0, "post_reset_req", 1, dummy);
    for (int i = 0; i < 6; i++) tick(1, 0, 32'h0, 1, 1);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      logic [31:0] rpc;
      lat_cfg = int'($urandom_range(0, 3));
      rb = ($urandom_range(0, 15) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                        : ($urandom & 32'h0000_03FF);
      tick(($urandom_range(0, 399) != 0), rb, rpc,
           ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7));
    end
    tick(1, 0, 32'h0, 1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
